// File: rtl/btn_step_arbiter_if.sv
// Button/step port bundle between the board-side requesters and the counter core.
// The slave side is the arbiter; the master side drives buttons and step_rdy.
interface btn_step_arbiter_if;
    logic up;
    logic down;
    logic step_rdy;
    logic step_up;
    logic step_down;
    logic held_up;
    logic held_down;

    modport master (
        output up, down, step_rdy,
        input  step_up, step_down, held_up, held_down
    );

    modport slave (
        input  up, down, step_rdy,
        output step_up, step_down, held_up, held_down
    );
endinterface

// File: rtl/btn_step_arbiter.sv
// Per-button sync, debounce and press/auto-repeat event generation, round-robin merged onto one step port.
// Auto-repeat is built only when AUTO_REPEAT_EN is defined; otherwise each press yields a single step.
module btn_step_arbiter #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned REP_DELAY  = 50000000,
    parameter int unsigned REP_PERIOD = 10000000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic              Clk100M,
    input  logic              Rst_n,
    btn_step_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;

    // Index 0 is the up requester, index 1 the down requester.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       pending;
    logic [1:0]       event_c;
    logic [1:0]       grant_c;
    logic [CNT_W-1:0] deb_cnt [2];
    state_t           state   [2];
`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt [2];
`endif
    logic             last_dn;
    logic             step_up;
    logic             step_down;

    // Every timing parameter must be nonzero and fit in the shared counter width.
    if (DEB_CYCLES == 0 || REP_DELAY == 0 || REP_PERIOD == 0 ||
        (64'(DEB_CYCLES) >> CNT_W) != 64'd0 ||
        (64'(REP_DELAY)  >> CNT_W) != 64'd0 ||
        (64'(REP_PERIOD) >> CNT_W) != 64'd0) begin : g_bad_cfg
        $error("btn_step_arbiter: CNT_W too narrow or zero timing parameter");
    end

    assign raw           = {bus.down, bus.up};
    assign bus.step_up   = step_up;
    assign bus.step_down = step_down;
    assign bus.held_up   = deb[0];
    assign bus.held_down = deb[1];

    // Press event on a fresh debounced rise; repeat events when the hold timer expires.
    always_comb begin
        event_c = '0;
        for (int i = 0; i < 2; i++) begin
            case (state[i])
                IDLE:    event_c[i] = deb[i];
`ifdef AUTO_REPEAT_EN
                WAIT:    event_c[i] = deb[i] && (rep_cnt[i] == CNT_W'(REP_DELAY - 1));
                REPEAT:  event_c[i] = deb[i] && (rep_cnt[i] == CNT_W'(REP_PERIOD - 1));
`endif
                default: event_c[i] = 1'b0;
            endcase
        end
    end

    // A lone pending request wins; on a tie the side opposite the last grant wins.
    always_comb begin
        grant_c = '0;
        if (bus.step_rdy) begin
            if (pending[0] && (!pending[1] || last_dn)) begin
                grant_c[0] = 1'b1;
            end else if (pending[1]) begin
                grant_c[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            pending   <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            last_dn   <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
                state[i]   <= IDLE;
`ifdef AUTO_REPEAT_EN
                rep_cnt[i] <= '0;
`endif
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end

                // Pending is a flag: events landing while it is set are lost.
                pending[i] <= pending[i] ? !grant_c[i] : event_c[i];

                if (!deb[i]) begin
                    state[i] <= IDLE;
`ifdef AUTO_REPEAT_EN
                    rep_cnt[i] <= '0;
`endif
                end else begin
                    case (state[i])
                        IDLE: begin
                            state[i] <= WAIT;
`ifdef AUTO_REPEAT_EN
                            rep_cnt[i] <= '0;
`endif
                        end
`ifdef AUTO_REPEAT_EN
                        WAIT: begin
                            if (event_c[i]) begin
                                state[i]   <= REPEAT;
                                rep_cnt[i] <= '0;
                            end else begin
                                rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
                            end
                        end
                        REPEAT: begin
                            if (event_c[i]) begin
                                rep_cnt[i] <= '0;
                            end else begin
                                rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end

            step_up   <= grant_c[0];
            step_down <= grant_c[1];
            if (grant_c[0]) begin
                last_dn <= 1'b0;
            end else if (grant_c[1]) begin
                last_dn <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_btn_step_arbiter.sv
// Directed bench for btn_step_arbiter: stimulus pushes expected {direction, cycle} steps,
// a monitor pops and compares each observed step pulse. Honours AUTO_REPEAT_EN.
module tb_btn_step_arbiter;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 8;

    typedef struct {
        bit          dn;
        int unsigned cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        e;

    always #5 clk = ~clk;

    btn_step_arbiter_if bus ();

    btn_step_arbiter #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP),
        .CNT_W      (26)
    ) dut (
        .Clk100M (clk),
        .Rst_n   (rst_n),
        .bus     (bus)
    );

    // Monitor: cyc numbers the rising edge just taken; outputs sampled 2 ns after it.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (bus.step_up === 1'b1 || bus.step_down === 1'b1) begin
            checks++;
            if (bus.step_up === 1'b1 && bus.step_down === 1'b1) begin
                errors++;
                $display("FAIL step_overlap cyc=%0d actual up=1 down=1 required at most one", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step cyc=%0d actual down=%0b required none", cyc, bus.step_down);
            end else begin
                e = exp_q.pop_front();
                if (e.dn != bus.step_down || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL step_match actual down=%0b cyc=%0d required down=%0b cyc=%0d",
                             bus.step_down, cyc, e.dn, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_step(input bit dn, input int unsigned at);
        exp_q.push_back('{dn, at});
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    int unsigned k;

    initial begin
        bus.up       = 1'b1;
        bus.down     = 1'b0;
        bus.step_rdy = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with up held
        check("rst_step_up", bus.step_up, 0);
        check("rst_step_down", bus.step_down, 0);
        check("rst_held_up", bus.held_up, 0);
        check("rst_held_down", bus.held_down, 0);
        k = cyc;
        rst_n = 1'b1;
        expect_step(1'b0, k + 8);
        wait_cyc(k + 5);
        check("held_up_before_deb", bus.held_up, 0);
        wait_cyc(k + 6);
        check("held_up_after_deb", bus.held_up, 1);
        wait_cyc(k + 8);
        bus.up = 1'b0;
        wait_cyc(k + 30);
        check_drained("reset_press_drained");
        check("held_up_released", bus.held_up, 0);

        // Bounce: toggling every 2 cycles never reaches the debounce count
        for (int i = 0; i < 15; i++) begin
            bus.up = ~bus.up;
            repeat (2) @(negedge clk);
            check("bounce_held_up", bus.held_up, 0);
        end
        bus.up = 1'b0;
        repeat (20) @(negedge clk);
        check_drained("bounce_drained");

        // Auto-repeat: down held 80 cycles, debounced level high until k+86
        k = cyc;
        bus.down = 1'b1;
        expect_step(1'b1, k + 8);
`ifdef AUTO_REPEAT_EN
        for (int n = 0; n < 8; n++) expect_step(1'b1, k + 8 + RD + n * RP);
`endif
        wait_cyc(k + 80);
        bus.down = 1'b0;
        wait_cyc(k + 110);
        check_drained("repeat_drained");
        check("held_down_released", bus.held_down, 0);

        // Tie after a down grant: up first
        k = cyc;
        bus.up = 1'b1;
        bus.down = 1'b1;
        expect_step(1'b0, k + 8);
        expect_step(1'b1, k + 9);
        wait_cyc(k + 10);
        bus.up = 1'b0;
        bus.down = 1'b0;
        wait_cyc(k + 30);
        check_drained("tie1_drained");

        // Lone up press leaves last grant = up
        k = cyc;
        bus.up = 1'b1;
        expect_step(1'b0, k + 8);
        wait_cyc(k + 10);
        bus.up = 1'b0;
        wait_cyc(k + 30);
        check_drained("lone_up_drained");

        // Tie after an up grant: down first
        k = cyc;
        bus.up = 1'b1;
        bus.down = 1'b1;
        expect_step(1'b1, k + 8);
        expect_step(1'b0, k + 9);
        wait_cyc(k + 10);
        bus.up = 1'b0;
        bus.down = 1'b0;
        wait_cyc(k + 30);
        check_drained("tie2_drained");

        // Backpressure: repeats while pending are dropped, one step once ready
        k = cyc;
        bus.step_rdy = 1'b0;
        bus.up = 1'b1;
        wait_cyc(k + 40);
        bus.up = 1'b0;
        wait_cyc(k + 60);
        check_drained("backpressure_no_step");
        k = cyc;
        bus.step_rdy = 1'b1;
        expect_step(1'b0, k + 1);
        wait_cyc(k + 20);
        check_drained("backpressure_drained");

        // Reset mid-pulse clears the step immediately and queues nothing
        k = cyc;
        bus.up = 1'b1;
        expect_step(1'b0, k + 8);
        wait_cyc(k + 8);
        check("midpulse_step_up_high", bus.step_up, 1);
        rst_n = 1'b0;
        bus.up = 1'b0;
        #1;
        check("midpulse_step_up_cleared", bus.step_up, 0);
        check("midpulse_held_up_cleared", bus.held_up, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_drained("post_reset_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
